// File: rtl/seg_pkg.sv
// Shared constants and types for 7-segment display paths.
// Segment patterns are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   typedef enum logic {
      ST_BLANK   = 1'b0,
      ST_DISPLAY = 1'b1
   } scan_state_e;

   // Segment + decimal-point payload driven to the display (both active-low)
   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
   } seg_dp_t;

   localparam seg_dp_t SEG_DP_OFF = '{seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit bus in / display drive out for seg_scan_driver.
//   master : digit source and display (drives enable, bcd_in, dp_in)
//   slave  : scan driver (drives AN, SEG, DP, frame_start)
interface seg_scan_driver_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      enable;
   logic [4*NUM_DIGITS-1:0]   bcd_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     AN;
   logic [6:0]                SEG;
   logic                      DP;
   logic                      frame_start;

   modport master (
      output enable, bcd_in, dp_in,
      input  AN, SEG, DP, frame_start
   );

   modport slave (
      input  enable, bcd_in, dp_in,
      output AN, SEG, DP, frame_start
   );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
//   bcd   : 4-bit input code
//   seg_c : {g,f,e,d,c,b,a}, active-low
module bcd_to_7seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_DASH;
      case (bcd)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with per-digit blanking gap
// and a once-per-frame snapshot of the digit bus.
//   clk_div : scan clock
//   BTN0    : asynchronous active-low reset
//   bus     : seg_scan_driver_if.slave (enable, bcd_in, dp_in -> AN, SEG, DP, frame_start)
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DIGIT_CYCLES = 1024,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic               clk_div,
   input  logic               BTN0,
   seg_scan_driver_if.slave   bus
);

   localparam int unsigned MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned BCD_W   = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   scan_state_e             state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    run_q, run_d;
   logic [BCD_W-1:0]        snap_bcd_q;
   logic [NUM_DIGITS-1:0]   snap_dp_q;
   logic                    capture;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   seg_dp_t                 disp_q, disp_d;
   logic                    fs_q, fs_d;

   logic [3:0]              cur_bcd;
   logic [6:0]              dec_seg;
   logic [NUM_DIGITS-1:0]   an_lit;
   seg_dp_t                 lit;

   // Decode the snapshot digit currently indexed
   assign cur_bcd = snap_bcd_q[{idx_q, 2'b00} +: 4];
   assign an_lit  = ~(NUM_DIGITS'(1) << idx_q);

   bcd_to_7seg u_dec (
      .bcd   (cur_bcd),
      .seg_c (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_blank;
   logic                  zeros_above;

   // lz_blank[i]: digit i and every higher digit are zero (digit 0 excluded)
   always_comb begin
      lz_blank    = '0;
      zeros_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zeros_above = zeros_above && (snap_bcd_q[4*i +: 4] == 4'd0);
         lz_blank[i] = zeros_above;
      end
   end

   always_comb begin
      lit.seg = lz_blank[idx_q] ? SEG_BLANK : dec_seg;
      lit.dp  = ~snap_dp_q[idx_q];
   end
`else
   always_comb begin
      lit.seg = dec_seg;
      lit.dp  = ~snap_dp_q[idx_q];
   end
`endif

   // Next-state and next-output logic; outputs are registered with the state
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      an_d    = an_q;
      disp_d  = disp_q;
      fs_d    = 1'b0;
      capture = 1'b0;

      if (!bus.enable) begin
         state_d = ST_BLANK;
         idx_d   = '0;
         cnt_d   = '0;
         run_d   = 1'b0;
         an_d    = '1;
         disp_d  = SEG_DP_OFF;
      end else if (!run_q) begin
         // First enabled cycle opens a fresh frame
         state_d = ST_BLANK;
         idx_d   = '0;
         cnt_d   = '0;
         run_d   = 1'b1;
         an_d    = '1;
         disp_d  = SEG_DP_OFF;
         fs_d    = 1'b1;
         capture = 1'b1;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_DISPLAY;
                  cnt_d   = '0;
                  an_d    = an_lit;
                  disp_d  = lit;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DISPLAY: begin
               if (cnt_q == DIGIT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  an_d    = '1;
                  disp_d  = SEG_DP_OFF;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     fs_d    = 1'b1;
                     capture = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_BLANK;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_div or negedge BTN0) begin
      if (!BTN0) begin
         state_q <= ST_BLANK;
         idx_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         an_q    <= '1;
         disp_q  <= SEG_DP_OFF;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         an_q    <= an_d;
         disp_q  <= disp_d;
         fs_q    <= fs_d;
      end
   end

   // Frame snapshot of the digit bus
   always_ff @(posedge clk_div or negedge BTN0) begin
      if (!BTN0) begin
         snap_bcd_q <= '0;
         snap_dp_q  <= '0;
      end else if (capture) begin
         snap_bcd_q <= bus.bcd_in;
         snap_dp_q  <= bus.dp_in;
      end
   end

   assign bus.AN          = an_q;
   assign bus.SEG         = disp_q.seg;
   assign bus.DP          = disp_q.dp;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with a frame-position reference model.
module tb_seg_scan_driver;

   localparam int ND    = 4;
   localparam int DC    = 4;
   localparam int BC    = 1;
   localparam int SLOT  = BC + DC;
   localparam int FRAME = ND * SLOT;

   logic clk_div = 1'b0;
   logic BTN0;

   always #5 clk_div = ~clk_div;

   seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg_scan_driver #(
      .NUM_DIGITS   (ND),
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk_div (clk_div),
      .BTN0    (BTN0),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: position within the frame plus the frame snapshot
   bit          m_run;
   int          m_pos;
   logic [15:0] m_bcd;
   logic [3:0]  m_dp;
   logic [6:0]  lut [16];

   function automatic logic [12:0] exp_out();
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic [3:0] v;
      int         d;
      bit         lz;
      an  = 4'hF;
      seg = 7'h7F;
      dp  = 1'b1;
      fs  = 1'b0;
      if (m_run) begin
         d  = m_pos / SLOT;
         fs = (m_pos == 0);
         if ((m_pos % SLOT) >= BC) begin
            an  = ~(4'b0001 << d);
            v   = m_bcd[4*d +: 4];
            seg = lut[v];
            dp  = ~m_dp[d];
            lz  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (d > 0) begin
               lz = 1'b1;
               for (int k = d; k < ND; k++)
                  if (m_bcd[4*k +: 4] != 4'd0) lz = 1'b0;
            end
`endif
            if (lz) seg = 7'h7F;
         end
      end
      return {an, seg, dp, fs};
   endfunction

   function automatic logic [12:0] act_out();
      return {bus.AN, bus.SEG, bus.DP, bus.frame_start};
   endfunction

   // Advance one clock and update the model with the inputs the DUT sampled
   task automatic tick();
      @(posedge clk_div);
      #1;
      if (!BTN0 || !bus.enable) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_pos = 0;
         m_bcd = bus.bcd_in;
         m_dp  = bus.dp_in;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
         if (m_pos == 0) begin
            m_bcd = bus.bcd_in;
            m_dp  = bus.dp_in;
         end
      end
   endtask

   task automatic wait_pos(input int pos, input string name);
      int n;
      n = 0;
      while (!(m_run && m_pos == pos) && n < 3 * FRAME) begin
         tick();
         n++;
      end
      checks++;
      if (!(m_run && m_pos == pos)) begin
         errors++;
         $display("FAIL %s_timeout: pos=%0d want %0d", name, m_pos, pos);
      end
   endtask

   task automatic test_reset();
      BTN0 = 1'b0;
      bus.enable = 1'b1;
      bus.bcd_in = 16'h1234;
      bus.dp_in  = 4'b0000;
      m_run = 1'b0;
      repeat (3) tick();
      checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", bus.AN); end
      checks++; if (bus.SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", bus.SEG); end
      checks++; if (bus.DP !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", bus.DP); end
      checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
   endtask

   task automatic test_first_frame();
      int fs_first;
      int fs_second;
      fs_first  = -1;
      fs_second = -1;
      BTN0 = 1'b1;
      for (int t = 0; t < 2 * FRAME; t++) begin
         tick();
         checks++;
         if (act_out() !== exp_out()) begin
            errors++;
            $display("FAIL first_frame t=%0d: got %h want %h", t, act_out(), exp_out());
         end
         if (bus.frame_start === 1'b1) begin
            if (fs_first < 0) fs_first = t;
            else if (fs_second < 0) fs_second = t;
         end
         if (t == 0) begin
            checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL first_fs: got %b want 1", bus.frame_start); end
         end
         if (t == 1 || t == 6 || t == 11 || t == 16) begin
            logic [10:0] want;
            case (t)
               1:       want = {4'b1110, 7'h19};
               6:       want = {4'b1101, 7'h30};
               11:      want = {4'b1011, 7'h24};
               default: want = {4'b0111, 7'h79};
            endcase
            checks++;
            if ({bus.AN, bus.SEG} !== want) begin
               errors++;
               $display("FAIL first_digit t=%0d: got %h want %h", t, {bus.AN, bus.SEG}, want);
            end
         end
      end
      checks++;
      if (fs_second - fs_first != FRAME) begin
         errors++;
         $display("FAIL frame_len: got %0d want %0d", fs_second - fs_first, FRAME);
      end
   endtask

   task automatic test_snapshot();
      wait_pos(7, "snap");
      bus.bcd_in = 16'h9999;
      for (int i = 1; i <= 2 * FRAME; i++) begin
         tick();
         checks++;
         if (act_out() !== exp_out()) begin
            errors++;
            $display("FAIL snapshot i=%0d: got %h want %h", i, act_out(), exp_out());
         end
         if (i == 5 || i == 10 || i == 15) begin
            logic [6:0] want;
            want = (i == 5) ? 7'h24 : (i == 10) ? 7'h79 : 7'h10;
            checks++;
            if (bus.SEG !== want) begin
               errors++;
               $display("FAIL snapshot_seg i=%0d: got %h want %h", i, bus.SEG, want);
            end
         end
      end
   endtask

   task automatic test_invalid_dp();
      bus.bcd_in = 16'h00A0;
      bus.dp_in  = 4'b0010;
      wait_pos(0, "inv");
      for (int i = 1; i < FRAME; i++) begin
         tick();
         checks++;
         if (act_out() !== exp_out()) begin
            errors++;
            $display("FAIL invalid_dp i=%0d: got %h want %h", i, act_out(), exp_out());
         end
         if (i == 1) begin
            checks++; if ({bus.SEG, bus.DP} !== {7'h40, 1'b1}) begin errors++; $display("FAIL inv_d0: got %h want 81", {bus.SEG, bus.DP}); end
         end
         if (i == 6) begin
            checks++; if ({bus.SEG, bus.DP} !== {7'h3F, 1'b0}) begin errors++; $display("FAIL inv_d1: got %h want 7e", {bus.SEG, bus.DP}); end
         end
         if (i == 11) begin
            checks++; if (bus.DP !== 1'b1) begin errors++; $display("FAIL inv_d2_dp: got %b want 1", bus.DP); end
         end
      end
   endtask

   task automatic test_enable();
      bus.bcd_in = 16'h1234;
      bus.dp_in  = 4'b0000;
      wait_pos(12, "en");
      bus.enable = 1'b0;
      tick();
      checks++; if (bus.AN !== 4'hF) begin errors++; $display("FAIL en_off_an: got %h want f", bus.AN); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (act_out() !== exp_out()) begin errors++; $display("FAIL en_off i=%0d: got %h want %h", i, act_out(), exp_out()); end
      end
      bus.enable = 1'b1;
      tick();
      checks++; if ({bus.AN, bus.frame_start} !== 5'b11111) begin errors++; $display("FAIL en_restart: got %b want 11111", {bus.AN, bus.frame_start}); end
      tick();
      checks++; if ({bus.AN, bus.SEG} !== {4'b1110, 7'h19}) begin errors++; $display("FAIL en_digit0: got %h want %h", {bus.AN, bus.SEG}, {4'b1110, 7'h19}); end
   endtask

   task automatic test_reset_mid();
      wait_pos(3, "rstmid");
      #2;
      BTN0 = 1'b0;
      #1;
      checks++; if ({bus.AN, bus.SEG, bus.DP} !== {4'hF, 7'h7F, 1'b1}) begin errors++; $display("FAIL rst_async: got %h want fff", {bus.AN, bus.SEG, bus.DP}); end
      m_run = 1'b0;
      repeat (2) tick();
      BTN0 = 1'b1;
      tick();
      checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL rst_restart_fs: got %b want 1", bus.frame_start); end
      for (int i = 0; i < FRAME; i++) begin
         tick();
         checks++;
         if (act_out() !== exp_out()) begin errors++; $display("FAIL rst_restart i=%0d: got %h want %h", i, act_out(), exp_out()); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.bcd_in = 16'($urandom);
            bus.dp_in  = 4'($urandom);
         end
         bus.enable = ($urandom_range(0, 59) != 0);
         tick();
         checks++;
         if (act_out() !== exp_out()) begin
            errors++;
            $display("FAIL random i=%0d: got %h want %h", i, act_out(), exp_out());
         end
      end
      bus.enable = 1'b1;
   endtask

`ifdef LEADING_ZERO_BLANK_EN
   task automatic test_leading_zero();
      bus.dp_in  = 4'b0000;
      bus.bcd_in = 16'h0005;
      wait_pos(0, "lz5");
      for (int i = 1; i < FRAME; i++) begin
         tick();
         if ((i % SLOT) == 1) begin
            logic [6:0] want;
            want = (i == 1) ? 7'h12 : 7'h7F;
            checks++;
            if (bus.SEG !== want) begin errors++; $display("FAIL lz5 i=%0d: got %h want %h", i, bus.SEG, want); end
         end
      end
      bus.bcd_in = 16'h0000;
      wait_pos(0, "lz0");
      for (int i = 1; i < FRAME; i++) begin
         tick();
         if ((i % SLOT) == 1) begin
            logic [6:0] want;
            want = (i == 1) ? 7'h40 : 7'h7F;
            checks++;
            if (bus.SEG !== want) begin errors++; $display("FAIL lz0 i=%0d: got %h want %h", i, bus.SEG, want); end
         end
      end
   endtask
`endif

   initial begin
      lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      m_pos = 0;
      m_bcd = '0;
      m_dp  = '0;
      test_reset();
      test_first_frame();
      test_snapshot();
      test_invalid_dp();
      test_enable();
      test_reset_mid();
      test_random();
`ifdef LEADING_ZERO_BLANK_EN
      test_leading_zero();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream consumer of the BCD counter stages.
- Takes NUM_DIGITS packed BCD digits plus per-digit decimal points and time-multiplexes them onto a common-anode 7-segment display.
- Drives active-low anodes and segments. Inserts a blanking gap between digits to prevent ghosting.
- Snapshots the digit bus once per scan frame so a count change mid-frame cannot tear the display.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (legal 2..8).
- DIGIT_CYCLES, 1024, clk_div cycles each digit's anode is held on (legal >=1).
- BLANK_CYCLES, 16, clk_div cycles all anodes are off before each digit (legal >=1).

Ports:
- clk_div  in  1  scan clock; all state updates on its rising edge.
- BTN0  in  1  reset, asynchronous, active-low.
- enable  in  1  scan enable, synchronous.
- bcd_in  in  4*NUM_DIGITS  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low when lit.
- SEG  out  7  {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse on the first BLANK cycle of digit 0.

Behaviour:
- Reset (BTN0=0, async):
  - AN = all 1s, SEG = 7'h7F, DP = 1, frame_start = 0.
  - State = BLANK, digit index = 0, cycle counter = 0, snapshot registers = 0.
- All outputs are registered and change only on clk_div edges.
- FSM has two states:
  - BLANK: AN all 1s, SEG 7'h7F, DP 1. After BLANK_CYCLES cycles, go to DISPLAY with the same index.
  - DISPLAY: AN[idx] = 0, all other AN bits 1; SEG and DP decoded from the snapshot for digit idx. After DIGIT_CYCLES cycles, go to BLANK and set idx = idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
- Snapshot:
  - On the cycle where frame_start is asserted, bcd_in and dp_in are captured into the snapshot registers.
  - DISPLAY uses only snapshot values.
  - Changes on bcd_in mid-frame appear from the next frame onward.
- Decode:
  - 0..9 use standard patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Codes 10..15 display a dash, 7'h3F.
- Output timing: AN/SEG/DP for DISPLAY become valid on the first DISPLAY cycle and stay stable for exactly DIGIT_CYCLES cycles. The AN bit is never low during BLANK.
- enable:
  - While 0: outputs are forced to the blank values, state = BLANK, idx = 0, counter = 0, frame_start = 0.
  - Deassertion mid-frame blanks on the next edge.
  - On the first enabled cycle, frame_start pulses and a fresh snapshot is taken.
- Reset mid-frame: immediate async return to reset values; the scan restarts from digit 0 after release.
- Counter width is clog2(max(DIGIT_CYCLES,BLANK_CYCLES)); no overflow beyond terminal count.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during DISPLAY, any digit i>0 whose snapshot value and all higher-digit snapshot values are 0 shows SEG 7'h7F. Its DP still follows the snapshot dp bit. Digit 0 is never blanked. Timing is unchanged.
- Undefined: every digit is decoded normally.

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - SEG_DASH = 7'h3F.
  - The 0..9 pattern constants.
  - The state encoding typedef (BLANK/DISPLAY).
- One sub-module bcd_to_7seg: combinational 4-bit in, 7-bit active-low out (dash for >9). Reusable by other display paths.

Test Plan:
- Bench settings: NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=1.
- Reset and first frame: hold BTN0=0 -> AN=4'hF, SEG=7'h7F, DP=1. Release with enable=1 and bcd_in=16'h1234 -> frame_start pulses, then AN=4'b1110/SEG=7'h19 for 4 cycles. The sequence continues to 4'b1101/7'h30, then 4'b1011/7'h24, then 4'b0111/7'h79, each preceded by 1 blank cycle; frame = 20 cycles.
- Snapshot: change bcd_in from 16'h1234 to 16'h9999 while digit 1 is displayed -> the remaining digits still show 2 and 1. The next frame shows 7'h10 on all digits.
- Invalid code and DP: bcd_in=16'h00A0, dp_in=4'b0010 -> digit 1 SEG=7'h3F with DP=0; the other digits show DP=1.
- Enable/reset mid-frame: drop enable during digit 2 -> next cycle AN=4'hF. Re-enable -> frame_start, digit 0 first. Assert BTN0=0 mid-DISPLAY -> AN=4'hF immediately, without waiting for a clock edge.
- LEADING_ZERO_BLANK_EN: with it defined, bcd_in=16'h0005 -> digits 3..1 SEG=7'h7F, digit 0 SEG=7'h12. bcd_in=16'h0000 -> only digit 0 shows 7'h40.
